// File: rtl/seven_seg_scanner_if.sv
// Bundle of the load/pattern inputs and board-pin outputs of the seven-segment scanner.
// SCAN_BLINK_EN adds the per-digit blinkMask input.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [7*NUM_DIGITS-1:0] segIn;
  logic [NUM_DIGITS-1:0]   digitEn;
`ifdef SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0]   blinkMask;
`endif
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              cathode;
  logic                    scanTick;

`ifdef SCAN_BLINK_EN
  modport master (output load, segIn, digitEn, blinkMask, input anode, cathode, scanTick);
  modport slave  (input load, segIn, digitEn, blinkMask, output anode, cathode, scanTick);
`else
  modport master (output load, segIn, digitEn, input anode, cathode, scanTick);
  modport slave  (input load, segIn, digitEn, output anode, cathode, scanTick);
`endif
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: prescaled slot counter, guard cycle per slot,
// per-digit enable. Optional blink phase when SCAN_BLINK_EN is defined.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
`ifdef SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRESCALE - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [7*NUM_DIGITS-1:0] hold;
  logic [6:0]              digit [NUM_DIGITS];
  logic                    slot_end;
  logic                    dark;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_on;
  logic [6:0]              seg_on;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign digit[i] = hold[7*i +: 7];
  end

  assign slot_end = (cnt == CNT_LAST);

`ifdef SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] frames;
  logic          phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames <= '0;
      phase  <= 1'b0;
    end else if (slot_end && (idx == IDX_LAST)) begin
      if (frames == FW'(BLINK_FRAMES - 1)) begin
        frames <= '0;
        phase  <= ~phase;
      end else begin
        frames <= frames + FW'(1);
      end
    end
  end

  assign dark = phase & bus.blinkMask[idx];
`else
  assign dark = 1'b0;
`endif

  // Cycle 0 of every slot is the anti-ghost guard; disabled digits still consume their slot.
  always_comb begin
    lit    = 1'b0;
    an_on  = '0;
    seg_on = '0;
    if ((cnt != '0) && bus.digitEn[idx] && !dark) begin
      lit = 1'b1;
    end
    if (lit) begin
      an_on  = NUM_DIGITS'(1) << idx;
      seg_on = digit[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      hold         <= '0;
      bus.anode    <= {NUM_DIGITS{INV}};
      bus.cathode  <= {7{INV}};
      bus.scanTick <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (bus.load) begin
        hold <= bus.segIn;
      end
      bus.anode    <= INV ? ~an_on  : an_on;
      bus.cathode  <= INV ? ~seg_on : seg_on;
      // Registered one early so the pulse coincides with cnt == PRESCALE-1.
      bus.scanTick <= (cnt == CNT_PRE);
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: elapsed-cycle reference model checked every cycle,
// plus directed literal scenarios (frame pattern, enable mask, mid-slot load, reset, blink).
module tb_seven_seg_scanner;
  localparam int N = 4;
  localparam int P = 4;
`ifdef SCAN_BLINK_EN
  localparam int BF = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS(N),
    .PRESCALE(P),
    .ACTIVE_LOW(1)
`ifdef SCAN_BLINK_EN
    , .BLINK_FRAMES(BF)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [N-1:0] bmask;
`ifdef SCAN_BLINK_EN
  assign bmask = bus.blinkMask;
`else
  assign bmask = '0;
`endif

  // Reference: n = edges since the last reset edge, so the counter is n mod P,
  // the digit is (n / P) mod N and the frame is n / (P*N).
  function automatic int lit_digit(input int n, input logic [N-1:0] en, input logic [N-1:0] mask);
    int d;
    bit ph;
    d  = (n / P) % N;
    ph = 1'b0;
`ifdef SCAN_BLINK_EN
    ph = (((n / (P * N)) / BF) % 2) == 1;
`endif
    if ((n % P) == 0) return -1;
    if (en[d] !== 1'b1) return -1;
    if (ph && mask[d]) return -1;
    return d;
  endfunction

  function automatic logic [N-1:0] model_anode(input int d);
    logic [N-1:0] a;
    a = '1;
    if (d >= 0) a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] model_cath(input int d, input logic [7*N-1:0] h);
    if (d < 0) return 7'h7F;
    return ~h[7*d +: 7];
  endfunction

  bit            mvalid = 1'b0;
  int            n = 0;
  logic [7*N-1:0] mhold = '0;
  logic [N-1:0]  e_an = '1;
  logic [6:0]    e_cat = 7'h7F;
  logic          e_tick = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      n      <= 0;
      mhold  <= '0;
      e_an   <= '1;
      e_cat  <= 7'h7F;
      e_tick <= 1'b0;
      mvalid <= 1'b1;
    end else begin
      e_an   <= model_anode(lit_digit(n, bus.digitEn, bmask));
      e_cat  <= model_cath(lit_digit(n, bus.digitEn, bmask), mhold);
      if (bus.load) mhold <= bus.segIn;
      n      <= n + 1;
      e_tick <= ((n + 1) % P) == (P - 1);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_anode", 32'(bus.anode), 32'(e_an));
      chk("model_cathode", 32'(bus.cathode), 32'(e_cat));
      chk("model_scanTick", 32'(bus.scanTick), 32'(e_tick));
    end
  end

  logic [3:0] fr_an  [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [6:0] fr_cat [16] = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h79, 7'h79,
                              7'h7F, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h30, 7'h30, 7'h30};

  initial begin
    int ticks;
    bit found;
    logic [6:0] prev_cat;
    bus.load    = 1'b0;
    bus.segIn   = '0;
    bus.digitEn = '1;
`ifdef SCAN_BLINK_EN
    bus.blinkMask = '0;
`endif
    rst_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_anode", 32'(bus.anode), 32'hF);
      chk("rst_cathode", 32'(bus.cathode), 32'h7F);
      chk("rst_scanTick", 32'(bus.scanTick), 32'h0);
    end

    rst_n       = 1'b1;
    bus.load    = 1'b1;
    bus.segIn   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    bus.digitEn = 4'hF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      chk("frame_anode", 32'(bus.anode), 32'(fr_an[i]));
      chk("frame_cathode", 32'(bus.cathode), 32'(fr_cat[i]));
      chk("frame_scanTick", 32'(bus.scanTick), ((i % 4) == 2) ? 32'h1 : 32'h0);
    end

    bus.digitEn = 4'b0101;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("mask_anode1_dark", 32'(bus.anode[1]), 32'h1);
      chk("mask_anode3_dark", 32'(bus.anode[3]), 32'h1);
      if (bus.scanTick === 1'b1) ticks++;
    end
    chk("mask_tick_count", 32'(ticks), 32'd4);

    bus.digitEn = 4'hF;
    bus.load    = 1'b1;
    bus.segIn   = {7'h4F, 7'h5B, 7'h06, 7'h06};
    @(negedge clk);
    bus.load = 1'b0;
    found    = 1'b0;
    prev_cat = bus.cathode;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (bus.anode === 4'hE && bus.cathode === 7'h79 && prev_cat === 7'h7F) found = 1'b1;
      prev_cat = bus.cathode;
    end
    chk("midslot_found_digit0", 32'(found), 32'h1);
    bus.load  = 1'b1;
    bus.segIn = {7'h4F, 7'h5B, 7'h06, 7'h7F};
    @(negedge clk);
    bus.load = 1'b0;
    chk("midslot_old_cathode", 32'(bus.cathode), 32'h79);
    chk("midslot_old_anode", 32'(bus.anode), 32'hE);
    @(negedge clk);
    chk("midslot_new_cathode", 32'(bus.cathode), 32'h00);
    chk("midslot_new_anode", 32'(bus.anode), 32'hE);

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (bus.anode === 4'hB) found = 1'b1;
    end
    chk("rstmid_found_digit2", 32'(found), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid_off_anode", 32'(bus.anode), 32'hF);
    chk("rstmid_off_cathode", 32'(bus.cathode), 32'h7F);
    chk("rstmid_off_tick", 32'(bus.scanTick), 32'h0);
    @(negedge clk);
    chk("rstmid_guard_anode", 32'(bus.anode), 32'hF);
    @(negedge clk);
    // hold was cleared by reset, so digit 0 lights with every segment off.
    chk("rstmid_digit0_anode", 32'(bus.anode), 32'hE);
    chk("rstmid_digit0_cathode", 32'(bus.cathode), 32'h7F);

`ifdef SCAN_BLINK_EN
    begin
      bit lit0 [6];
      bit lit_other [6];
      rst_n = 1'b0;
      bus.blinkMask = 4'b0001;
      @(negedge clk);
      rst_n       = 1'b1;
      bus.load    = 1'b1;
      bus.segIn   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
      bus.digitEn = 4'hF;
      for (int f = 0; f < 6; f++) begin
        lit0[f] = 1'b0;
        lit_other[f] = 1'b0;
      end
      for (int j = 0; j < 96; j++) begin
        @(negedge clk);
        bus.load = 1'b0;
        if (bus.anode[0] === 1'b0) lit0[j / 16] = 1'b1;
        if (bus.anode[3:1] !== 3'b111) lit_other[j / 16] = 1'b1;
      end
      for (int f = 0; f < 6; f++) begin
        chk("blink_digit0_lit", 32'(lit0[f]), (f == 2 || f == 3) ? 32'h0 : 32'h1);
        chk("blink_others_lit", 32'(lit_other[f]), 32'h1);
      end
    end
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
